run_monitor: RTL and testbench

//  Synthesizable run controller and result checker for the 8051 core top.

---
 rtl/run_monitor_pkg.sv | 22 ++
 rtl/rm_match_counter.sv | 46 ++++
 rtl/run_monitor.sv | 140 ++++++++++++++
 tb/tb_run_monitor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run monitor: FSM state encoding and a
// constant-friendly ceil(log2) used to size the internal counters.
package run_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rm_match_counter.sv
// Counts consecutive clocks where obs equals the expected value and flags the
// clock on which the run of matches reaches STABLE_CYCLES.
module rm_match_counter
   import run_monitor_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] obs,
   input  logic [DATA_W-1:0] expect_val,
   output logic              hit
);

   localparam int SW = (clog2(STABLE_CYCLES + 1) < 1) ? 1 : clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

   logic          match;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;

   always_comb begin
      match        = (obs == expect_val);
      hit          = en && match && (stable_cnt_q == LAST);
      stable_cnt_d = stable_cnt_q;
      if (clr) begin
         stable_cnt_d = '0;
      end else if (en) begin
         // Holding at LAST keeps the count from wrapping if enable lingers.
         if (!match)
            stable_cnt_d = '0;
         else if (stable_cnt_q != LAST)
            stable_cnt_d = stable_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stable_cnt_q <= '0;
      else
         stable_cnt_q <= stable_cnt_d;
   end

endmodule

// File: rtl/run_monitor.sv
// Run controller: holds the core in reset, releases it, then waits for obs to
// settle on the expected value or times out; reports run length and activity.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int RST_CYCLES    = 5,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 1024,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] expect_val,
   input  logic [DATA_W-1:0] obs,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timed_out,
   output logic [CNT_W-1:0]  cycles,
   output logic [CNT_W-1:0]  changes
);

   localparam int RW = (clog2(RST_CYCLES + 1) < 1) ? 1 : clog2(RST_CYCLES + 1);
   localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [DATA_W-1:0] expect_q, expect_d;
   logic [DATA_W-1:0] obs_prev_q, obs_prev_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [CNT_W-1:0]  changes_q, changes_d;
   logic              core_rst_q, core_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timed_out_q, timed_out_d;
   logic              in_run;
   logic              hit;

   assign in_run = (state_q == ST_RUN);

   rm_match_counter #(
      .DATA_W        (DATA_W),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_match (
      .clk        (clk),
      .rst        (rst),
      .clr        (!in_run),
      .en         (in_run),
      .obs        (obs),
      .expect_val (expect_q),
      .hit        (hit)
   );

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      expect_d   = expect_q;
      obs_prev_d = obs_prev_q;
      cycles_d   = cycles_q;
      changes_d  = changes_q;

      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
               state_d   = ST_RESET;
               expect_d  = expect_val;
               cycles_d  = '0;
               changes_d = '0;
               rst_cnt_d = '0;
            end
         end
         ST_RESET: begin
            if (rst_cnt_q == RST_LAST)
               state_d = ST_RUN;
            else
               rst_cnt_d = rst_cnt_q + RW'(1);
         end
         ST_RUN: begin
            cycles_d   = cycles_q + CNT_W'(1);
            obs_prev_d = obs;
            // cycles_q==0 marks the first RUN clock, where obs_prev is not yet valid.
            if ((cycles_q != '0) && (obs != obs_prev_q) && (changes_q != '1))
               changes_d = changes_q + CNT_W'(1);
            if (hit)
               state_d = ST_PASS;
            else if (cycles_q == TO_LAST)
               state_d = ST_FAIL;
         end
         default: state_d = ST_IDLE;
      endcase

      core_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
      busy_d      = (state_d == ST_RESET) || (state_d == ST_RUN);
      done_d      = (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_d      = (state_d == ST_PASS);
      timed_out_d = (state_d == ST_FAIL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rst_cnt_q   <= '0;
         expect_q    <= '0;
         obs_prev_q  <= '0;
         cycles_q    <= '0;
         changes_q   <= '0;
         core_rst_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         expect_q    <= expect_d;
         obs_prev_q  <= obs_prev_d;
         cycles_q    <= cycles_d;
         changes_q   <= changes_d;
         core_rst_q  <= core_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign core_rst  = core_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timed_out = timed_out_q;
   assign cycles    = cycles_q;
   assign changes   = changes_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a table of complete runs plus hand-written
// sequences for reset, ignored start pulses and mid-run abort.
module tb_run_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  expect_val;
   logic [7:0]  obs;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timed_out;
   logic [15:0] cycles;
   logic [15:0] changes;

   int n_checks = 0;
   int n_fail   = 0;

   run_monitor #(
      .DATA_W        (8),
      .RST_CYCLES    (5),
      .STABLE_CYCLES (4),
      .TIMEOUT       (1024),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .expect_val (expect_val),
      .obs        (obs),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .timed_out  (timed_out),
      .cycles     (cycles),
      .changes    (changes)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] exp_v;
      logic [7:0] obs_a;
      logic [7:0] obs_b;
      int         sw_at;
      int         sw_len;
      logic       exp_pass;
      int         exp_cycles;
      int         exp_changes;
   } run_vec_t;

   run_vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_one(input int idx, input run_vec_t v);
      int rc;
      int e_done;
      int k;
      logic [15:0] cyc_snap;
      e_done = -1;
      obs        = v.obs_a;
      expect_val = v.exp_v;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      expect_val = 8'hFF;
      rc = (core_rst && busy) ? 1 : 0;
      for (int e = 1; e <= 1200; e++) begin
         k = e - 5;
         obs = (k >= v.sw_at && k < v.sw_at + v.sw_len) ? v.obs_b : v.obs_a;
         tick();
         if (core_rst && busy) rc++;
         if (done) begin
            e_done = e;
            break;
         end
      end
      check($sformatf("v%0d reset_hold_clks", idx), rc, 5);
      check($sformatf("v%0d done_edge", idx), e_done, 5 + v.exp_cycles);
      check($sformatf("v%0d pass", idx), pass, v.exp_pass);
      check($sformatf("v%0d timed_out", idx), timed_out, !v.exp_pass);
      check($sformatf("v%0d cycles", idx), cycles, v.exp_cycles);
      check($sformatf("v%0d changes", idx), changes, v.exp_changes);
      check($sformatf("v%0d busy_after", idx), busy, 0);
      check($sformatf("v%0d core_rst_after", idx), core_rst, 0);
      cyc_snap = cycles;
      obs = ~obs;
      repeat (3) tick();
      check($sformatf("v%0d cycles_frozen", idx), cycles, v.exp_cycles);
      check($sformatf("v%0d changes_frozen", idx), changes, v.exp_changes);
      check($sformatf("v%0d done_held", idx), done, 1);
      if (cyc_snap != cycles) $display("note: cycles moved after done");
   endtask

   initial begin
      //        exp    a      b      at    len   pass cyc   chg
      vecs[0] = '{8'h2A, 8'h2A, 8'h2A, 1,    0,    1'b1, 4,    0};
      vecs[1] = '{8'h2A, 8'h2A, 8'h2B, 4,    1,    1'b1, 8,    2};
      vecs[2] = '{8'h10, 8'h00, 8'h00, 1,    0,    1'b0, 1024, 0};
      vecs[3] = '{8'h55, 8'h00, 8'h55, 1021, 2000, 1'b1, 1024, 1};
      vecs[4] = '{8'h55, 8'h55, 8'h55, 1,    0,    1'b1, 4,    0};
      vecs[5] = '{8'h80, 8'h80, 8'h00, 2,    2,    1'b1, 7,    2};

      rst = 1'b1; start = 1'b0; expect_val = 8'h00; obs = 8'h00;
      repeat (5) tick();
      check("rst core_rst", core_rst, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst pass", pass, 0);
      check("rst timed_out", timed_out, 0);
      check("rst cycles", cycles, 0);
      check("rst changes", changes, 0);
      rst = 1'b0;
      tick();
      check("idle busy", busy, 0);

      // Start pulses during RESET and RUN must not restart anything; rst aborts.
      expect_val = 8'h77; obs = 8'h00; start = 1'b1;
      tick();                         // edge 0
      start = 1'b0; tick();           // edge 1
      start = 1'b1; tick();           // edge 2, ignored
      start = 1'b0; tick(); tick();   // edges 3,4
      check("seq reset core_rst e4", core_rst, 1);
      tick();                         // edge 5 -> RUN
      check("seq run core_rst e5", core_rst, 0);
      tick(); tick();                 // run clks 1,2
      start = 1'b1; tick();           // run clk 3, ignored
      start = 1'b0; tick(); tick();   // run clks 4,5
      check("seq run busy", busy, 1);
      check("seq run cycles", cycles, 5);
      check("seq run done", done, 0);
      rst = 1'b1; tick();
      check("abort core_rst", core_rst, 1);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort pass", pass, 0);
      check("abort timed_out", timed_out, 0);
      check("abort cycles", cycles, 0);
      start = 1'b1; tick();
      check("rst_vs_start busy", busy, 0);
      rst = 1'b0; start = 1'b0; tick();
      check("rst_vs_start idle", busy, 0);
      check("rst_vs_start core_rst", core_rst, 1);

      for (int i = 0; i < 6; i++) run_one(i, vecs[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
